mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction fetcher and the memory-access stage of the pipelined ARM32 CPU.
- Each request is a single 32-bit word read or write. Data-side requests have priority, and a starvation counter bounds how long fetch can be held off.
- Sits between the fetcher/memaccessor request ports and the memory macro, and sequences each access through a fixed-latency memory.
- Exports `busy` so the CPU pipeline FSM can stall stages while the port is occupied.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_priority_select.sv | 21 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared width constant and state/owner types for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int BIT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_priority_select.sv
// Grant decision between fetch and data; data wins unless fetch has been held off
// for MAX_DATA_STREAK consecutive data grants.
module arb_priority_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 3,
  parameter int STREAK_W        = 2
) (
  input  logic                fetch_req,
  input  logic                data_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_fetch,
  output logic                grant_data
);

  always_comb begin
    grant_data  = data_req && (!fetch_req || (streak < STREAK_W'(MAX_DATA_STREAK)));
    grant_fetch = fetch_req && !grant_data;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// sequencing each word access through a fixed-latency memory macro.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 fetch_req,
  input  logic [BIT_WIDTH-1:0] fetch_addr,
  output logic                 fetch_ack,
  output logic [BIT_WIDTH-1:0] fetch_rdata,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [BIT_WIDTH-1:0] data_addr,
  input  logic [BIT_WIDTH-1:0] data_wdata,
  output logic                 data_ack,
  output logic [BIT_WIDTH-1:0] data_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  output logic                 busy
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int LAT_W    = 2;

  arb_state_t           state_q, state_d;
  owner_t               owner_q;
  logic                 we_q;
  logic [BIT_WIDTH-1:0] addr_q, wdata_q;
  logic [BIT_WIDTH-1:0] fetch_rdata_q, data_rdata_q;
  logic [LAT_W-1:0]     lat_cnt_q;
  logic [STREAK_W-1:0]  streak_q;
  logic                 grant_fetch, grant_data;

  arb_priority_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK),
    .STREAK_W        (STREAK_W)
  ) u_priority_select (
    .fetch_req   (fetch_req),
    .data_req    (data_req),
    .streak      (streak_q),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_fetch || grant_data) state_d = ISSUE;
      // Writes complete as soon as the strobe is issued; only reads wait out the latency.
      ISSUE:   state_d = (owner_q == OWNER_DATA && we_q) ? ACK : WAIT;
      WAIT:    if (lat_cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_FETCH;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      lat_cnt_q     <= '0;
      streak_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (grant_data) begin
            owner_q <= OWNER_DATA;
            addr_q  <= data_addr;
            we_q    <= data_we;
            wdata_q <= data_wdata;
            // Only data grants that actually hold off a waiting fetch count toward starvation.
            if (!fetch_req)
              streak_q <= '0;
            else if (streak_q != STREAK_W'(MAX_DATA_STREAK))
              streak_q <= streak_q + STREAK_W'(1);
          end else if (grant_fetch) begin
            owner_q  <= OWNER_FETCH;
            addr_q   <= fetch_addr;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            streak_q <= '0;
          end
        end
        ISSUE: lat_cnt_q <= LAT_W'(MEM_LATENCY - 1);
        WAIT: begin
          if (lat_cnt_q == '0) begin
            if (owner_q == OWNER_DATA) data_rdata_q <= mem_rdata;
            else                       fetch_rdata_q <= mem_rdata;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    mem_en      = (state_q == ISSUE);
    mem_we      = mem_en && (owner_q == OWNER_DATA) && we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    fetch_ack   = (state_q == ACK) && (owner_q == OWNER_FETCH);
    data_ack    = (state_q == ACK) && (owner_q == OWNER_DATA);
    fetch_rdata = fetch_rdata_q;
    data_rdata  = data_rdata_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (nreset && state_q == IDLE) begin
      assert (!(grant_data && data_addr[1:0] != 2'b00) && !(grant_fetch && fetch_addr[1:0] != 2'b00));
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected issues/acks are queued when requests
// are driven and retired by a negedge monitor as the DUT strobes memory and acks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  int          cyc = 0;

  logic        fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0;
  logic        fetch_ack, data_ack, mem_en, mem_we, busy;
  logic [31:0] fetch_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        l3_fetch_req = 1'b0, l3_data_req = 1'b0, l3_data_we = 1'b0;
  logic [31:0] l3_fetch_addr = '0, l3_data_addr = '0, l3_data_wdata = '0;
  logic        l3_fetch_ack, l3_data_ack, l3_mem_en, l3_mem_we, l3_busy;
  logic [31:0] l3_fetch_rdata, l3_data_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(3)) dut (
    .clk(clk), .nreset(nreset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .MAX_DATA_STREAK(3)) dut3 (
    .clk(clk), .nreset(nreset),
    .fetch_req(l3_fetch_req), .fetch_addr(l3_fetch_addr), .fetch_ack(l3_fetch_ack), .fetch_rdata(l3_fetch_rdata),
    .data_req(l3_data_req), .data_we(l3_data_we), .data_addr(l3_data_addr), .data_wdata(l3_data_wdata),
    .data_ack(l3_data_ack), .data_rdata(l3_data_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  function automatic logic [31:0] pattern(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hE3A0_0001;
      32'h0000_0020: return 32'hE59F_1004;
      32'h0000_0200: return 32'h1234_5678;
      32'h0000_0300: return 32'hCAFE_0001;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory models: one remembered write overlays the fixed read pattern.
  logic        wr_seen = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_pipe = '0;
  logic [31:0] l3_pipe0 = '0, l3_pipe1 = '0, l3_pipe2 = '0;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_seen <= 1'b1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    rd_pipe  <= (mem_en && !mem_we) ? ((wr_seen && mem_addr == wr_addr) ? wr_data : pattern(mem_addr))
                                    : 32'hBAD0_BAD0;
    l3_pipe0 <= (l3_mem_en && !l3_mem_we) ? pattern(l3_mem_addr) : 32'hBAD0_BAD0;
    l3_pipe1 <= l3_pipe0;
    l3_pipe2 <= l3_pipe1;
  end
  assign mem_rdata    = rd_pipe;
  assign l3_mem_rdata = l3_pipe2;

  typedef struct {
    logic        is_data;
    logic        check_rdata;
    logic [31:0] rdata;
    int          cyc;
  } ack_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } iss_exp_t;

  ack_exp_t ack_q[$];
  iss_exp_t iss_q[$];
  int vectors = 0, miscompares = 0;
  int mem_en_cnt = 0, ack_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expect_access(input logic is_data, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int grant_cyc, input int lat);
    iss_q.push_back('{we: we, addr: addr, wdata: wdata, cyc: grant_cyc + 1});
    ack_q.push_back('{is_data: is_data, check_rdata: !we, rdata: rdata,
                      cyc: grant_cyc + (we ? 2 : lat + 2)});
  endtask

  initial begin
    iss_exp_t ie;
    ack_exp_t ae;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (mem_en) begin
          mem_en_cnt++;
          checkOutput("mem_en_expected", 32'(iss_q.size() != 0), 32'd1);
          if (iss_q.size() != 0) begin
            ie = iss_q.pop_front();
            checkOutput("issue_cycle", 32'(cyc), 32'(ie.cyc));
            checkOutput("issue_addr", mem_addr, ie.addr);
            checkOutput("issue_we", 32'(mem_we), 32'(ie.we));
            if (ie.we) checkOutput("issue_wdata", mem_wdata, ie.wdata);
          end
        end
        if (fetch_ack || data_ack) begin
          ack_cnt++;
          checkOutput("single_ack", 32'(fetch_ack && data_ack), 32'd0);
          checkOutput("ack_expected", 32'(ack_q.size() != 0), 32'd1);
          if (ack_q.size() != 0) begin
            ae = ack_q.pop_front();
            checkOutput("ack_owner", 32'(data_ack), 32'(ae.is_data));
            checkOutput("ack_cycle", 32'(cyc), 32'(ae.cyc));
            if (ae.check_rdata)
              checkOutput("ack_rdata", ae.is_data ? data_rdata : fetch_rdata, ae.rdata);
          end
        end
      end
    end
  end

  task automatic drop_all();
    fetch_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
  endtask

  // One isolated access on the latency-1 DUT, checking busy each cycle until its ack.
  task automatic applyStimulus(input logic is_data, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int   n;
    int   ack_cyc;
    logic got;
    @(posedge clk); #1;
    n = cyc;
    ack_cyc = n + ((is_data && we) ? 2 : 3);
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
    end else begin
      fetch_req = 1'b1; fetch_addr = addr;
    end
    expect_access(is_data, is_data && we, addr, is_data ? wdata : 32'h0, exp_rdata, n, 1);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      checkOutput("busy", 32'(busy), 32'(cyc > n && cyc <= ack_cyc));
      if (fetch_ack || data_ack) got = 1'b1;
    end
    checkOutput("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    drop_all();
  endtask

  initial begin
    int   n, s, en0, ack0, l3_en;
    logic got, is_d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_acks", 32'({fetch_ack, data_ack}), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;

    applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hE3A0_0001);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0000_0024, 32'h0, pattern(32'h0000_0024));

    // Both requesters held continuously: grant order follows the bench's streak model.
    @(posedge clk); #1;
    n = cyc;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0020;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0300;
    s = 0;
    for (int i = 0; i < 5; i++) begin
      is_d = (s < 3);
      if (is_d) begin
        s = (s < 3) ? s + 1 : 3;
        expect_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, pattern(32'h0000_0300), n + 4 * i, 1);
      end else begin
        s = 0;
        expect_access(1'b0, 1'b0, 32'h0000_0020, 32'h0, pattern(32'h0000_0020), n + 4 * i, 1);
      end
      if (i == 3) begin
        while (cyc < n + 13) @(negedge clk);
        checkOutput("streak_after_fetch", 32'(dut.streak_q), 32'(s));
      end
    end
    while (cyc < n + 19) @(negedge clk);
    @(posedge clk); #1;
    drop_all();

    // A data request pulsed while fetch owns the port must vanish without a grant.
    en0 = mem_en_cnt; ack0 = ack_cnt;
    @(posedge clk); #1;
    n = cyc;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0010;
    expect_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hE3A0_0001, n, 1);
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0300;
    @(posedge clk); #1;
    data_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (fetch_ack || data_ack) got = 1'b1;
    end
    checkOutput("pulse_fetch_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    drop_all();
    repeat (4) @(negedge clk);
    checkOutput("pulse_en_vs_ack", 32'(mem_en_cnt - en0), 32'(ack_cnt - ack0));

    // Reset during WAIT of a fetch: the access is abandoned and never acked.
    @(posedge clk); #1;
    n = cyc;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0020;
    iss_q.push_back('{we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, cyc: n + 1});
    while (cyc < n + 2) @(negedge clk);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    #2;
    nreset = 1'b0;
    fetch_req = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("arst_acks", 32'({fetch_ack, data_ack}), 32'd0);
    checkOutput("arst_mem_addr", mem_addr, 32'd0);
    checkOutput("arst_fetch_rdata", fetch_rdata, 32'd0);
    checkOutput("arst_data_rdata", data_rdata, 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 32'({busy, fetch_ack}), 32'd0);
    end

    // Latency-3 data read on the second instance.
    @(posedge clk); #1;
    n = cyc;
    l3_data_req = 1'b1; l3_data_we = 1'b0; l3_data_addr = 32'h0000_0200;
    got = 1'b0; l3_en = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (l3_mem_en) l3_en++;
      if (l3_data_ack) begin
        got = 1'b1;
        checkOutput("l3_ack_cycle", 32'(cyc), 32'(n + 5));
        checkOutput("l3_rdata", l3_data_rdata, pattern(32'h0000_0200));
      end
    end
    checkOutput("l3_ack_seen", 32'(got), 32'd1);
    checkOutput("l3_mem_en_once", 32'(l3_en), 32'd1);
    @(posedge clk); #1;
    l3_data_req = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("ack_q_drained", 32'(ack_q.size()), 32'd0);
    checkOutput("iss_q_drained", 32'(iss_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
